data_memory_bytelane: RTL and testbench

// - Parametrised RV32 data memory, successor to the word-only DataMemory.
// - Byte-addressed, with byte/half/word loads and stores, sign or zero extension,
//   a valid/ready handshake and a post-reset zero-fill sequencer.
// - Sits between the MEM stage and writeback. One request per cycle; registered read data.

---
 rtl/data_memory_bytelane.sv | 143 ++++++++++++++
 tb/tb_data_memory_bytelane.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bytelane.sv
// Byte-addressed RV32 data memory: LB/LH/LW/LBU/LHU/SB/SH/SW, zero-fill on reset.
// Optional DMEM_ERR_EN reports misaligned/reserved/out-of-range accesses on ERR.
module data_memory_bytelane #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic              UNSIGNED,
  input  logic [ADDR_W-1:0] ADDr,
  input  logic [31:0]       Din,
  output logic              READY,
  output logic              VALID,
  output logic [31:0]       Dout,
  output logic              ERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = ADDR_W - 2;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t      r_state, w_state_nxt;
  logic [IW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [DEPTH];
  logic        r_valid, r_err;
  logic [31:0] r_dout;

  logic [AW-1:0] w_widx;
  logic [IW-1:0] w_idx;
  logic          w_inr, w_err, w_acc, w_we;
  logic [1:0]    w_size;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_word, w_ld;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign READY  = (r_state == S_IDLE);
  assign VALID  = r_valid;
  assign Dout   = r_dout;
  assign ERR    = r_err;

  assign w_widx = ADDr[ADDR_W-1:2];
  assign w_idx  = w_widx[IW-1:0];
  assign w_inr  = (w_widx < AW'(DEPTH));
  assign w_size = (SIZE == 2'b11) ? 2'b10 : SIZE;
  assign w_acc  = RST_N & EN & READY;
  assign w_we   = w_acc & RW & w_inr & ~w_err;

`ifdef DMEM_ERR_EN
  assign w_err = (SIZE == 2'b11)
               | ((SIZE == 2'b01) & ADDr[0])
               | ((SIZE == 2'b10) & (|ADDr[1:0]))
               | ~w_inr;
`else
  assign w_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (INIT_CLEAR == 0 || r_cnt == IW'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = Din;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << ADDr[1:0];
        w_wdata = {4{Din[7:0]}};
      end
      2'b01: begin
        w_be    = ADDr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Din[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = Din;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (r_state == S_INIT) begin
      if (INIT_CLEAR != 0) r_mem[r_cnt] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
    end
  end

  assign w_word = w_inr ? r_mem[w_idx] : '0;
  assign w_byte = w_word[{ADDr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{ADDr[1], 4'b0000} +: 16];

  always_comb begin
    w_ld = w_word;
    case (w_size)
      2'b00:   w_ld = {{24{~UNSIGNED & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{~UNSIGNED & w_half[15]}}, w_half};
      default: w_ld = w_word;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_valid <= w_acc;
      r_err   <= w_acc & w_err;
      r_dout  <= (w_acc & ~RW & w_inr & ~w_err) ? w_ld : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomized + directed bench for data_memory_bytelane against a byte-array model.
// Works with or without DMEM_ERR_EN defined.
module tb_data_memory_bytelane;

  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic        UNS = 1'b0;
  logic [31:0] ADDr = '0;
  logic [31:0] Din = '0;
  logic        READY, VALID, ERR;
  logic [31:0] Dout;

  data_memory_bytelane #(
    .DEPTH(DEPTH), .ADDR_W(32), .INIT_CLEAR(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .RW(RW),
    .SIZE(SIZE), .UNSIGNED(UNS), .ADDr(ADDr), .Din(Din),
    .READY(READY), .VALID(VALID), .Dout(Dout), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_mem [DEPTH*4];
  bit          m_ready = 0;
  int          m_fill  = 0;
  bit          exp_v = 0, exp_e = 0;
  logic [31:0] exp_d = '0;
  bit          armed = 0;
  bit          obs_v, obs_e;
  logic [31:0] obs_d;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_access(input bit rw, input logic [1:0] size,
                                     input bit uns, input logic [31:0] addr,
                                     input logic [31:0] din,
                                     output logic [31:0] d, output bit e);
    int     idx  = int'(addr >> 2);
    bit     inr  = (idx < DEPTH);
    int     sz   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int     base = int'(addr) - (int'(addr) % sz);
    longint v    = 0;
    e = 0;
`ifdef DMEM_ERR_EN
    e = (size == 2'd3) || ((int'(addr) % sz) != 0) || !inr;
`endif
    d = '0;
    if (!e && inr) begin
      if (rw) begin
        for (int i = 0; i < sz; i++) m_mem[base+i] = din[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++)
          v = v | (longint'(m_mem[base+i]) << (8*i));
        if (!uns && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
        d = v[31:0];
      end
    end
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit rw,
                       input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] din);
    @(negedge CLK);
    obs_v = VALID;
    obs_d = Dout;
    obs_e = ERR;
    if (armed) begin
      chk("ready", {31'b0, READY}, {31'b0, m_ready});
      chk("valid", {31'b0, VALID}, {31'b0, exp_v});
      chk("dout", Dout, exp_d);
      if (exp_v) chk("err", {31'b0, ERR}, {31'b0, exp_e});
    end
    RST_N = rst; EN = en; RW = rw; SIZE = size;
    UNS = uns; ADDr = addr; Din = din;
    exp_d = '0;
    exp_e = 0;
    if (!rst) begin
      m_ready = 0;
      m_fill  = 0;
      exp_v   = 0;
      for (int i = 0; i < DEPTH*4; i++) m_mem[i] = 8'h00;
    end else if (!m_ready) begin
      exp_v = 0;
      m_fill++;
      if (m_fill == DEPTH) m_ready = 1;
    end else begin
      exp_v = en;
      if (en) ref_access(rw, size, uns, addr, din, exp_d, exp_e);
    end
    armed = 1;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 2'd0, 0, 32'h0, 32'h0);
  endtask

  task automatic req(input bit rw, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] din);
    cycle(1, 1, rw, size, uns, addr, din);
  endtask

  task automatic wait_ready(input string tag);
    int lat = 0;
    idle();
    while (!READY && lat < 200) begin
      lat++;
      idle();
    end
    chk(tag, lat, DEPTH);
  endtask

  int pulses;

  initial begin
    cycle(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    cycle(0, 1, 0, 2'd2, 0, 32'h0, 32'h0);
    chk("rst_ready", {31'b0, READY}, 32'h0);
    chk("rst_valid", {31'b0, VALID}, 32'h0);
    chk("rst_dout", Dout, 32'h0);
    wait_ready("ready_lat");

    req(0, 2'd2, 0, 32'h14, 0);
    idle();
    chk("zero_v", {31'b0, obs_v}, 32'h1);
    chk("zero_d", obs_d, 32'h0);

    req(1, 2'd2, 0, 32'h10, 32'h8899AABB);
    req(0, 2'd0, 0, 32'h11, 0);
    req(0, 2'd0, 1, 32'h11, 0);
    chk("lb", obs_d, 32'hFFFFFFAA);
    req(0, 2'd1, 0, 32'h12, 0);
    chk("lbu", obs_d, 32'h000000AA);
    req(0, 2'd2, 0, 32'h10, 0);
    chk("lh", obs_d, 32'hFFFF8899);
    idle();
    chk("lw", obs_d, 32'h8899AABB);

    req(1, 2'd2, 0, 32'h20, 32'h0);
    req(1, 2'd0, 0, 32'h23, 32'hFFFFFF5A);
    req(1, 2'd1, 0, 32'h20, 32'hABCD1234);
    req(0, 2'd2, 0, 32'h20, 0);
    idle();
    chk("lane_merge", obs_d, 32'h5A001234);

    req(1, 2'd2, 0, 32'h30, 32'hCAFEF00D);
    req(0, 2'd2, 0, 32'h30, 0);
    idle();
    chk("raw", obs_d, 32'hCAFEF00D);

    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      req(0, 2'd2, 0, 32'(4*i), 0);
      if (i > 0 && obs_v) pulses++;
    end
    idle();
    if (obs_v) pulses++;
    chk("burst_pulses", pulses, 8);

`ifdef DMEM_ERR_EN
    req(1, 2'd1, 0, 32'h01, 32'hFFFF);
    req(1, 2'd2, 0, 32'h02, 32'hFFFFFFFF);
    chk("err_sh", {31'b0, obs_e}, 32'h1);
    req(0, 2'd3, 0, 32'h00, 0);
    chk("err_sw", {31'b0, obs_e}, 32'h1);
    req(0, 2'd2, 0, 32'(DEPTH*4), 0);
    chk("err_sz3", {31'b0, obs_e}, 32'h1);
    chk("err_sz3_d", obs_d, 32'h0);
    req(0, 2'd2, 0, 32'h00, 0);
    chk("err_oor", {31'b0, obs_e}, 32'h1);
    idle();
    chk("err_unchanged", obs_d, 32'h0);
`else
    req(1, 2'd2, 0, 32'h02, 32'h11223344);
    req(0, 2'd2, 0, 32'h00, 0);
    chk("sw_forced_err", {31'b0, obs_e}, 32'h0);
    req(0, 2'd3, 0, 32'h00, 0);
    chk("sw_forced", obs_d, 32'h11223344);
    req(0, 2'd2, 0, 32'(DEPTH*4), 0);
    chk("sz3_as_word", obs_d, 32'h11223344);
    idle();
    chk("oor_load", obs_d, 32'h0);
`endif

    for (int i = 0; i < 400; i++)
      cycle(1, ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, DEPTH*4 + 15)), $urandom);

    req(0, 2'd2, 0, 32'h10, 0);
    cycle(0, 1, 0, 2'd2, 0, 32'h10, 0);
    repeat (30) cycle(1, 1, 0, 2'd2, 0, 32'h10, 0);
    cycle(0, 1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    wait_ready("refill_lat");
    req(0, 2'd2, 0, 32'h10, 0);
    idle();
    chk("refill_zero", obs_d, 32'h0);

    for (int i = 0; i < 200; i++)
      cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, DEPTH*4 + 15)), $urandom);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
